// File: rtl/gray_run_if.sv
// Control/status bundle between a host and gray_run_controller.
// start is a level request taken only in IDLE; done is a one-cycle pulse; stop is honoured only in RUN.
interface gray_run_if #(
  parameter int STEP_W = 8,
  parameter int HIT_W  = 8
);
  logic              start;
  logic              stop;
  logic [STEP_W-1:0] step_count;
  logic              det_in;
  logic              cnt_clr;
  logic              cnt_enable;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [STEP_W-1:0] steps_done;
  logic [HIT_W-1:0]  hit_count;

  modport master (
    output start, stop, step_count, det_in,
    input  cnt_clr, cnt_enable, busy, done, aborted, steps_done, hit_count
  );

  modport slave (
    input  start, stop, step_count, det_in,
    output cnt_clr, cnt_enable, busy, done, aborted, steps_done, hit_count
  );
endinterface

// File: rtl/gray_run_controller.sv
// Run sequencer for the 4-bit Gray counter/detector: clear, N enables, drain, done pulse.
// Optional GRAY_RUN_STOP_ON_HIT_EN: the first detector hit in RUN ends the run early (not an abort).
module gray_run_controller #(
  parameter int STEP_W       = 8,
  parameter int HIT_W        = 8,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  gray_run_if.slave  bus,
  output logic [2:0] dbg_state
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [STEP_W-1:0] n_q;
  logic [STEP_W-1:0] steps_q;
  logic [HIT_W-1:0]  hits_q;
  logic              aborted_q;
  logic              det_q;
  logic [DW-1:0]     drain_q;
  logic              accept;
  logic              hit;
  logic              hit_stop;
  logic              last_step;

  assign accept    = (state == IDLE) && bus.start;
  // det_in stays high while the counter is held, so only rising edges count.
  assign hit       = (state inside {RUN, DRAIN}) && bus.det_in && !det_q;
  assign last_step = (steps_q == n_q - 1'b1);

`ifdef GRAY_RUN_STOP_ON_HIT_EN
  assign hit_stop = hit && (state == RUN);
`else
  assign hit_stop = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CLEAR;
      CLEAR:   state_nxt = (n_q != '0) ? RUN : DRAIN;
      RUN:     if (bus.stop || last_step || hit_stop) state_nxt = DRAIN;
      DRAIN:   if (drain_q == DRAIN_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q       <= '0;
      steps_q   <= '0;
      hits_q    <= '0;
      aborted_q <= 1'b0;
      det_q     <= 1'b0;
      drain_q   <= '0;
    end else begin
      if (accept) begin
        n_q       <= bus.step_count;
        steps_q   <= '0;
        hits_q    <= '0;
        aborted_q <= 1'b0;
        det_q     <= 1'b0;
      end else begin
        if (state inside {CLEAR, RUN, DRAIN}) det_q <= bus.det_in;
        if (state == RUN) begin
          steps_q <= steps_q + 1'b1;
          if (bus.stop) aborted_q <= 1'b1;
        end
        if (hit && (hits_q != '1)) hits_q <= hits_q + 1'b1;
      end
      drain_q <= (state == DRAIN) ? drain_q + 1'b1 : '0;
    end
  end

  assign bus.cnt_clr    = (state == CLEAR);
  assign bus.cnt_enable = (state == RUN);
  assign bus.busy       = (state inside {CLEAR, RUN, DRAIN});
  assign bus.done       = (state == DONE);
  assign bus.aborted    = aborted_q;
  assign bus.steps_done = steps_q;
  assign bus.hit_count  = hits_q;
  assign dbg_state      = state;

endmodule
